// File: rtl/taxi_reset_seq.sv
// Power-on reset sequencer: waits for a stable clock-source lock, holds, then
// releases rst_out bits one at a time (bit 0 first) and counts aborted sequences.
`timescale 1ns/1ps
module taxi_reset_seq #(
   parameter int N_OUT       = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8,
   parameter int SYNC_N      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lock,
   input  logic             sw_rst,
   output logic [N_OUT-1:0] rst_out,
   output logic             done,
   output logic [7:0]       restart_cnt
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int SW = $clog2(STEP_CYCLES + 1);
   localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

   // rst asserts immediately; its release is retimed to clk before reaching the logic
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync_q <= 2'b11;
      else     rst_sync_q <= {rst_sync_q[0], 1'b0};
   end

   assign rst_int = rst_sync_q[1];

   logic [SYNC_N-1:0] lock_sync_q;
   logic              lock_s;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) lock_sync_q <= '0;
      else         lock_sync_q <= {lock_sync_q[SYNC_N-2:0], lock};
   end

   assign lock_s = lock_sync_q[SYNC_N-1];

   state_t            state_q, state_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [SW-1:0]     step_cnt_q, step_cnt_d;
   logic [IW-1:0]     rel_idx_q, rel_idx_d;
   logic [N_OUT-1:0]  rst_out_q, rst_out_d;
   logic              done_q, done_d;
   logic [7:0]        restart_cnt_q, restart_cnt_d;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         state_q       <= WAIT_LOCK;
         hold_cnt_q    <= '0;
         step_cnt_q    <= '0;
         rel_idx_q     <= '0;
         rst_out_q     <= '1;
         done_q        <= 1'b0;
         restart_cnt_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         step_cnt_q    <= step_cnt_d;
         rel_idx_q     <= rel_idx_d;
         rst_out_q     <= rst_out_d;
         done_q        <= done_d;
         restart_cnt_q <= restart_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      step_cnt_d    = step_cnt_q;
      rel_idx_d     = rel_idx_q;
      rst_out_d     = rst_out_q;
      done_d        = done_q;
      restart_cnt_d = restart_cnt_q;

      // Abort outranks any release scheduled for the same edge
      if (state_q != WAIT_LOCK && (!lock_s || sw_rst)) begin
         state_d    = WAIT_LOCK;
         hold_cnt_d = '0;
         step_cnt_d = '0;
         rel_idx_d  = '0;
         rst_out_d  = '1;
         done_d     = 1'b0;
         if ((state_q == RELEASE || state_q == RUN) && restart_cnt_q != 8'hFF)
            restart_cnt_d = restart_cnt_q + 8'd1;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               if (lock_s && !sw_rst) state_d = HOLD;
            end
            HOLD: begin
               if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                  hold_cnt_d   = '0;
                  rst_out_d[0] = 1'b0;
                  if (N_OUT == 1) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = RELEASE;
                     rel_idx_d = IW'(1);
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1);
               end
            end
            RELEASE: begin
               if (step_cnt_q == SW'(STEP_CYCLES - 1)) begin
                  step_cnt_d           = '0;
                  rst_out_d[rel_idx_q] = 1'b0;
                  if (rel_idx_q == IW'(N_OUT - 1)) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                  end else begin
                     rel_idx_d = rel_idx_q + IW'(1);
                  end
               end else begin
                  step_cnt_d = step_cnt_q + SW'(1);
               end
            end
            RUN: begin
            end
            default: state_d = WAIT_LOCK;
         endcase
      end
   end

   assign rst_out     = rst_out_q;
   assign done        = done_q;
   assign restart_cnt = restart_cnt_q;

endmodule

// File: tb/tb_taxi_reset_seq.sv
// Directed scoreboard bench for taxi_reset_seq: expectations are queued with the
// cycle they are due and compared on the falling edge of that cycle.
`timescale 1ns/1ps
module tb_taxi_reset_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock;
   logic       sw_rst;
   logic [3:0] rst_out;
   logic       done;
   logic [7:0] restart_cnt;

   always #5 clk = ~clk;

   taxi_reset_seq #(
      .N_OUT(4), .HOLD_CYCLES(16), .STEP_CYCLES(8), .SYNC_N(2)
   ) dut (
      .clk(clk), .rst(rst), .lock(lock), .sw_rst(sw_rst),
      .rst_out(rst_out), .done(done), .restart_cnt(restart_cnt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      string      tag;
      logic [3:0] ro;
      logic       dn;
      logic [7:0] rc;
   } exp_t;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] rc_exp;

   task automatic push(input int c, input string tag, input logic [3:0] ro, input logic dn);
      exp_t e;
      e.cyc = c; e.tag = tag; e.ro = ro; e.dn = dn; e.rc = rc_exp;
      sb_q.push_back(e);
   endtask

   // Release i falls at T0+16+8*i; check the cycle before and the release cycle
   task automatic push_seq(input int t0, input string tag, input int n);
      logic [3:0] pre, post;
      for (int i = 0; i < n; i++) begin
         pre  = 4'hF << i;
         post = 4'hF << (i + 1);
         push(t0 + 15 + 8 * i, $sformatf("%s_pre%0d", tag, i), pre, 1'b0);
         push(t0 + 16 + 8 * i, $sformatf("%s_rel%0d", tag, i), post, (i == 3));
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic reset_pulse();
      rst = 1'b1; lock = 1'b0; sw_rst = 1'b0; rc_exp = 8'd0;
      push(cyc + 1, "reset_state", 4'hF, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         n_tests++;
         $display("[TB] cyc=%0d %s rst_out=%b done=%b restart_cnt=%0d", cyc, e.tag, rst_out, done, restart_cnt);
         assert (e.cyc == cyc && {rst_out, done, restart_cnt} === {e.ro, e.dn, e.rc}) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: got rst_out=%b done=%b restart_cnt=%0d, expected rst_out=%b done=%b restart_cnt=%0d at cyc=%0d",
                   e.tag, cyc, rst_out, done, restart_cnt, e.ro, e.dn, e.rc, e.cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d checks pending", sb_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, t1, c;
      rst = 1'b1; lock = 1'b0; sw_rst = 1'b0; rc_exp = 8'd0;
      @(negedge clk);

      // Basic sequence: lock rises 3 cycles after reset release
      reset_pulse();
      t0 = cyc + 3; lock = 1'b1;
      push(t0, "basic_t0", 4'hF, 1'b0);
      push_seq(t0, "basic", 4);
      wait_to(t0 + 41);

      // Lock loss in RELEASE, then relock and a full restart
      reset_pulse();
      t0 = cyc + 3; lock = 1'b1;
      push_seq(t0, "lockloss", 2);
      push(t0 + 30, "lockloss_pre", 4'b1100, 1'b0);
      rc_exp = 8'd1;
      push(t0 + 31, "lockloss_abort", 4'hF, 1'b0);
      wait_to(t0 + 28); lock = 1'b0;
      wait_to(t0 + 33); lock = 1'b1;
      t1 = t0 + 36;
      push(t1 - 1, "relock_wait", 4'hF, 1'b0);
      push_seq(t1, "relock", 4);
      wait_to(t1 + 41);

      // sw_rst pulse during HOLD: no count, hold timer restarts
      reset_pulse();
      t0 = cyc + 3; lock = 1'b1;
      t1 = t0 + 6;
      push(t0 + 5, "hold_abort", 4'hF, 1'b0);
      push(t0 + 16, "hold_no_early_rel", 4'hF, 1'b0);
      push_seq(t1, "hold_restart", 4);
      wait_to(t0 + 4); sw_rst = 1'b1;
      @(negedge clk); sw_rst = 1'b0;
      wait_to(t1 + 41);

      // sw_rst high across the cycle ending at the rst_out[1] release edge
      reset_pulse();
      t0 = cyc + 3; lock = 1'b1;
      push_seq(t0, "coll", 1);
      push(t0 + 23, "coll_pre", 4'b1110, 1'b0);
      rc_exp = 8'd1;
      push(t0 + 24, "coll_abort", 4'hF, 1'b0);
      push(t0 + 32, "coll_held", 4'hF, 1'b0);
      t1 = t0 + 25;
      push_seq(t1, "coll_restart", 4);
      wait_to(t0 + 23); sw_rst = 1'b1;
      @(negedge clk); sw_rst = 1'b0;
      wait_to(t1 + 41);

      // 260 aborts from RUN: counter saturates at 255
      for (int k = 0; k < 260; k++) begin
         c = cyc;
         sw_rst = 1'b1;
         rc_exp = (rc_exp == 8'hFF) ? 8'hFF : rc_exp + 8'd1;
         if (k < 2 || k >= 252) begin
            push(c + 1, $sformatf("sat_abort%0d", k), 4'hF, 1'b0);
            push(c + 42, $sformatf("sat_run%0d", k), 4'h0, 1'b1);
         end
         @(negedge clk); sw_rst = 1'b0;
         wait_to(c + 42);
      end

      // Async reset mid-RELEASE: outputs return before the next clock edge
      c = cyc;
      sw_rst = 1'b1;
      push(c + 1, "async_abort", 4'hF, 1'b0);
      t0 = c + 2;
      push_seq(t0, "async", 2);
      push(t0 + 26, "async_pre", 4'b1100, 1'b0);
      @(negedge clk); sw_rst = 1'b0;
      wait_to(t0 + 26);
      @(posedge clk); #1;
      rst = 1'b1; rc_exp = 8'd0;
      push(cyc, "async_rst", 4'hF, 1'b0);
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);

      n_tests++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
